// File: rtl/preemphasis.sv
// Pre-emphasis / integrator inverse: d[n] = s[n] - s[n-1] + (s[n-1] >>> SHIFT).
// Enable-strobed, two-stage pipeline with saturating output and clip counter.
module preemphasis #(
  parameter int BITS_IN     = 12,
  parameter int BITS_OUT    = 16,
  parameter int SHIFT       = 4,
  parameter int ATTENUATION = 0,
  parameter int CNT_BITS    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic signed [BITS_OUT-1:0] data_in,
  output logic signed [BITS_IN-1:0]  data_out,
  output logic                       data_valid,
  output logic                       saturated,
  output logic [CNT_BITS-1:0]        sat_count
);

  localparam int AW = BITS_OUT + 2;
  localparam int TW = AW + ATTENUATION;

  localparam logic signed [TW-1:0]      T_MAX = TW'((2 ** (BITS_IN - 1)) - 1);
  localparam logic signed [TW-1:0]      T_MIN = -T_MAX - TW'(1);
  localparam logic signed [BITS_IN-1:0] O_MAX = {1'b0, {(BITS_IN - 1){1'b1}}};
  localparam logic signed [BITS_IN-1:0] O_MIN = {1'b1, {(BITS_IN - 1){1'b0}}};

  typedef enum logic {PRIME, RUN} state_t;

  function automatic logic is_clip(input logic signed [TW-1:0] t);
    return (t > T_MAX) || (t < T_MIN);
  endfunction

  function automatic logic signed [BITS_IN-1:0] clip(input logic signed [TW-1:0] t);
    if (t > T_MAX)      return O_MAX;
    else if (t < T_MIN) return O_MIN;
    else                return t[BITS_IN-1:0];
  endfunction

  state_t                      state_q, state_d;
  logic signed [BITS_OUT-1:0]  s_cur_q, s_cur_d;
  logic signed [BITS_OUT-1:0]  s_prev_q, s_prev_d;
  logic                        v0_q, v0_d;
  logic signed [AW-1:0]        acc_q, acc_d;
  logic                        v1_q, v1_d;
  logic signed [BITS_IN-1:0]   data_out_q, data_out_d;
  logic                        data_valid_q, data_valid_d;
  logic                        saturated_q, saturated_d;
  logic [CNT_BITS-1:0]         sat_count_q, sat_count_d;

  logic signed [AW-1:0]        cur_x, prev_x;
  logic signed [TW-1:0]        acc_x, t_scaled;
  logic                        clip_now, fire;

  // Stage 0: history capture and PRIME/RUN tracking
  always_comb begin
    state_d  = state_q;
    s_cur_d  = s_cur_q;
    s_prev_d = s_prev_q;
    v0_d     = 1'b0;
    if (flush) begin
      state_d  = PRIME;
      s_cur_d  = '0;
      s_prev_d = '0;
    end else if (enable) begin
      state_d  = RUN;
      s_prev_d = s_cur_q;
      s_cur_d  = data_in;
      v0_d     = (state_q == RUN);
    end
  end

  // Stage 1: difference plus leak term, wide enough that it never wraps
  always_comb begin
    cur_x  = s_cur_q;
    prev_x = s_prev_q;
    acc_d  = cur_x - prev_x + (prev_x >>> SHIFT);
    v1_d   = v0_q & ~flush;
  end

  // Stage 2: gain, clip, and clip accounting; a flush kills the sample leaving stage 1
  always_comb begin
    acc_x        = acc_q;
    t_scaled     = acc_x <<< ATTENUATION;
    clip_now     = is_clip(t_scaled);
    fire         = v1_q & ~flush;
    data_out_d   = data_out_q;
    data_valid_d = fire;
    saturated_d  = fire & clip_now;
    sat_count_d  = sat_count_q;
    if (fire) data_out_d = clip(t_scaled);
    if (fire && clip_now && (sat_count_q != {CNT_BITS{1'b1}}))
      sat_count_d = sat_count_q + CNT_BITS'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= PRIME;
      s_cur_q      <= '0;
      s_prev_q     <= '0;
      v0_q         <= 1'b0;
      acc_q        <= '0;
      v1_q         <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      saturated_q  <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      s_cur_q      <= s_cur_d;
      s_prev_q     <= s_prev_d;
      v0_q         <= v0_d;
      acc_q        <= acc_d;
      v1_q         <= v1_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      saturated_q  <= saturated_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign saturated  = saturated_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_preemphasis.sv
// Directed bench for preemphasis with a queue-based behavioural reference.
module tb_preemphasis;
  localparam int BI = 12, BO = 16, SH = 4, AT = 0, CB = 8;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic signed [BO-1:0] data_in = '0;
  logic signed [BI-1:0] data_out;
  logic data_valid, saturated;
  logic [CB-1:0] sat_count;

  preemphasis #(.BITS_IN(BI), .BITS_OUT(BO), .SHIFT(SH), .ATTENUATION(AT), .CNT_BITS(CB)) dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .saturated(saturated), .sat_count(sat_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: each accepted sample with history yields clip(d * 2^AT) two edges later.
  typedef struct { int due; int val; bit sat; } pend_t;
  pend_t q[$];
  pend_t p;
  int cyc = 0;
  bit primed = 1'b0;
  int m_cur = 0, m_prev = 0, md = 0, mc = 0;
  bit m_valid = 1'b0, m_sat = 1'b0;
  int m_out = 0, m_cnt = 0;

  function automatic int clip_i(input int v);
    int hi, lo;
    hi = (1 << (BI - 1)) - 1;
    lo = -(1 << (BI - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      q.delete();
      primed = 1'b0; m_cur = 0; m_prev = 0;
      m_valid = 1'b0; m_sat = 1'b0; m_out = 0; m_cnt = 0;
    end else begin
      if (flush) begin
        q.delete();
        primed = 1'b0; m_cur = 0; m_prev = 0;
      end else if (enable) begin
        m_prev = m_cur;
        m_cur = int'(data_in);
        if (primed) begin
          md = (m_cur - m_prev + (m_prev >>> SH)) * (1 << AT);
          mc = clip_i(md);
          q.push_back('{cyc + 2, mc, (mc != md)});
        end
        primed = 1'b1;
      end
      m_valid = 1'b0;
      m_sat = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        p = q.pop_front();
        m_valid = 1'b1;
        m_out = p.val;
        m_sat = p.sat;
        if (p.sat && m_cnt < CNT_MAX) m_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("model_valid", longint'(data_valid), longint'(m_valid));
      chk("model_sat", longint'(saturated), longint'(m_sat));
      chk("model_cnt", longint'(sat_count), longint'(m_cnt));
      chk("model_out", longint'(data_out), longint'(m_out));
    end
  end

  task automatic step(input logic en, input logic fl, input int v);
    enable = en;
    flush = fl;
    data_in = BO'(v);
    @(negedge clock);
    #1;
  endtask

  int first, nv, s, x;

  initial begin
    @(negedge clock);
    #1;
    chk("rst_out", longint'(data_out), 0);
    chk("rst_valid", longint'(data_valid), 0);
    chk("rst_sat", longint'(saturated), 0);
    chk("rst_cnt", longint'(sat_count), 0);
    reset = 1'b0;

    // Constant sum of 1600: leak term alone gives 100
    first = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, 1600);
      if (data_valid && first == 0) first = i;
      if (data_valid) begin
        chk("const_out", longint'(data_out), 100);
        chk("const_sat", longint'(saturated), 0);
      end
    end
    chk("first_valid_edge", first, 4);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // Positive and negative clipping
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 2048);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("pos_clip_valid", longint'(data_valid), 1);
    chk("pos_clip_out", longint'(data_out), 2047);
    chk("pos_clip_sat", longint'(saturated), 1);
    chk("pos_clip_cnt", longint'(sat_count), 1);
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, -2049);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("neg_clip_out", longint'(data_out), -2048);
    chk("neg_clip_cnt", longint'(sat_count), 2);

    // Loopback through an integrator, enable every third cycle
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 0);
    s = 0;
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 3000)) - 1500;
      s = s + x - (s >>> SH);
      step(1'b1, 1'b0, s);
      step(1'b0, 1'b0, s);
      step(1'b0, 1'b0, s);
      chk("loop_valid", longint'(data_valid), 1);
      chk("loop_out", longint'(data_out), longint'(x));
    end

    // Reset while a sample sits in stage 2
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 500);
    step(1'b1, 1'b0, 900);
    step(1'b0, 1'b0, 0);
    reset = 1'b1;
    step(1'b0, 1'b0, 0);
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0);
      if (data_valid) nv++;
    end
    step(1'b1, 1'b0, 700);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 0);
      if (data_valid) nv++;
    end
    chk("reset_drop_valids", nv, 0);

    // Flush together with enable while two samples are in flight
    step(1'b1, 1'b0, 100);
    step(1'b1, 1'b0, 300);
    step(1'b1, 1'b0, 200);
    step(1'b1, 1'b1, 500);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 0);
      if (data_valid) nv++;
    end
    step(1'b1, 1'b0, 800);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 0);
      if (data_valid) nv++;
    end
    chk("flush_drop_valids", nv, 0);

    // Counter saturation: 301 clipped samples
    step(1'b0, 1'b1, 0);
    nv = 0;
    for (int i = 0; i < 302; i++) begin
      step(1'b1, 1'b0, (i % 2 == 1) ? 20000 : 0);
      if (data_valid) nv++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0);
      if (data_valid) nv++;
    end
    chk("sat_valid_count", nv, 301);
    chk("sat_count_hold", longint'(sat_count), CNT_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
